// File: rtl/irq_pkg.sv
// ---------------------------------------------------------------------------
// irq_pkg
//   Shared definitions for the three-bus interrupt scheduler:
//     NCH / NBUS   : channels per request bus and number of buses
//     CHW / BUSW   : widths of the granted channel index and bus code
//     irq_state_e  : scheduler FSM states (IDLE, GRANT, SERVICE)
//     BUS_A/B/C    : bus codes as presented on gnt_bus
//     lowest_idx() : index of the lowest set bit of a request vector
// ---------------------------------------------------------------------------
package irq_pkg;

    localparam int NCH  = 9;
    localparam int NBUS = 3;
    localparam int CHW  = 4;
    localparam int BUSW = 2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_SERVICE = 2'd2
    } irq_state_e;

    localparam logic [BUSW-1:0] BUS_A = 2'd0;
    localparam logic [BUSW-1:0] BUS_B = 2'd1;
    localparam logic [BUSW-1:0] BUS_C = 2'd2;

    // Lowest set bit wins. The vector is zero-extended to 16 bits so the
    // helper works for any channel count that fits in CHW bits. Scanning
    // from the top down lets the last assignment (lowest index) stick.
    function automatic logic [CHW-1:0] lowest_idx(input logic [15:0] v);
        logic [CHW-1:0] idx;
        idx = '0;
        for (int i = 15; i >= 0; i--) begin
            if (v[i]) begin
                idx = CHW'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/irq_prio_resolve.sv
// ---------------------------------------------------------------------------
// irq_prio_resolve
//   Purely combinational fixed-priority resolver over three buses of
//   eligible interrupt bits. Bus A beats B, B beats C; inside a bus the
//   lowest channel index wins.
//   Ports:
//     elig_a/b/c : NCH eligible bits per bus (pending AND enable)
//     any        : at least one bit is eligible
//     bus        : winning bus code (BUS_A/BUS_B/BUS_C), 0 when none
//     ch         : winning channel index, 0 when none
// ---------------------------------------------------------------------------
module irq_prio_resolve
    import irq_pkg::*;
#(
    parameter int NCH = irq_pkg::NCH
) (
    input  logic [NCH-1:0]  elig_a,
    input  logic [NCH-1:0]  elig_b,
    input  logic [NCH-1:0]  elig_c,
    output logic            any,
    output logic [BUSW-1:0] bus,
    output logic [CHW-1:0]  ch
);

    logic any_a;
    logic any_b;
    logic any_c;

    assign any_a = |elig_a;
    assign any_b = |elig_b;
    assign any_c = |elig_c;

    always_comb begin
        any = any_a | any_b | any_c;
        bus = BUS_A;
        ch  = '0;
        if (any_a) begin
            bus = BUS_A;
            ch  = lowest_idx(16'(elig_a));
        end else if (any_b) begin
            bus = BUS_B;
            ch  = lowest_idx(16'(elig_b));
        end else if (any_c) begin
            bus = BUS_C;
            ch  = lowest_idx(16'(elig_c));
        end
    end

endmodule

// File: rtl/irq_sched.sv
// ---------------------------------------------------------------------------
// irq_sched
//   Three-bus interrupt scheduler. Request levels are latched into pending
//   registers; pending bits that are enabled compete through a fixed
//   priority resolver. The winner is granted, held until acknowledged,
//   then kept in service until end-of-interrupt. No preemption.
//
//   Handshake: a grant is offered while gnt_valid=1 (GRANT state only) and
//   is taken on any rising edge where gnt_ack=1; gnt_bus/gnt_ch never
//   change while offered. eoi is only honoured in SERVICE; gnt_ack is only
//   honoured in GRANT. When both arrive in GRANT, only the ack is taken.
//
//   Ports:
//     clk, rst            : clock, synchronous active-high reset
//     req_a/b/c [NCH]     : request levels per bus (bit 0 = highest prio)
//     en [NCH]            : per-channel enable shared by all buses
//     gnt_ack, eoi        : grant acceptance, end of interrupt
//     gnt_valid           : grant presented (GRANT state)
//     gnt_bus [2], gnt_ch [4] : granted bus code and channel index
//     busy                : in GRANT or SERVICE
//     pend_a/b/c [NCH]    : pending registers
//     state_dbg           : current FSM state
// ---------------------------------------------------------------------------
module irq_sched
    import irq_pkg::*;
#(
    parameter int NCH = irq_pkg::NCH
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NCH-1:0]  req_a,
    input  logic [NCH-1:0]  req_b,
    input  logic [NCH-1:0]  req_c,
    input  logic [NCH-1:0]  en,
    input  logic            gnt_ack,
    input  logic            eoi,
    output logic            gnt_valid,
    output logic [BUSW-1:0] gnt_bus,
    output logic [CHW-1:0]  gnt_ch,
    output logic            busy,
    output logic [NCH-1:0]  pend_a,
    output logic [NCH-1:0]  pend_b,
    output logic [NCH-1:0]  pend_c,
    output irq_state_e      state_dbg
);

    irq_state_e      state_q,   state_d;
    logic [NCH-1:0]  pend_a_q,  pend_a_d;
    logic [NCH-1:0]  pend_b_q,  pend_b_d;
    logic [NCH-1:0]  pend_c_q,  pend_c_d;
    logic [BUSW-1:0] gnt_bus_q, gnt_bus_d;
    logic [CHW-1:0]  gnt_ch_q,  gnt_ch_d;

    logic [NCH-1:0]  elig_a;
    logic [NCH-1:0]  elig_b;
    logic [NCH-1:0]  elig_c;
    logic            res_any;
    logic [BUSW-1:0] res_bus;
    logic [CHW-1:0]  res_ch;

    logic [NCH-1:0]  ch_onehot;
    logic [NCH-1:0]  clr_a;
    logic [NCH-1:0]  clr_b;
    logic [NCH-1:0]  clr_c;

    // Masked pending bits stay in the register; they simply do not compete.
    assign elig_a = pend_a_q & en;
    assign elig_b = pend_b_q & en;
    assign elig_c = pend_c_q & en;

    irq_prio_resolve #(
        .NCH (NCH)
    ) u_resolve (
        .elig_a (elig_a),
        .elig_b (elig_b),
        .elig_c (elig_c),
        .any    (res_any),
        .bus    (res_bus),
        .ch     (res_ch)
    );

    assign ch_onehot = NCH'(1) << gnt_ch_q;

    // Next state, grant capture and pending-clear selection.
    always_comb begin
        state_d   = state_q;
        gnt_bus_d = gnt_bus_q;
        gnt_ch_d  = gnt_ch_q;
        clr_a     = '0;
        clr_b     = '0;
        clr_c     = '0;
        case (state_q)
            ST_IDLE: begin
                if (res_any) begin
                    state_d   = ST_GRANT;
                    gnt_bus_d = res_bus;
                    gnt_ch_d  = res_ch;
                end
            end
            ST_GRANT: begin
                // eoi is deliberately not looked at here.
                if (gnt_ack) begin
                    state_d = ST_SERVICE;
                    case (gnt_bus_q)
                        BUS_A:   clr_a = ch_onehot;
                        BUS_B:   clr_b = ch_onehot;
                        BUS_C:   clr_c = ch_onehot;
                        default: ;
                    endcase
                end
            end
            ST_SERVICE: begin
                if (eoi) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // A request in the same cycle as the clear of its own bit wins,
    // so a requester holding its line keeps the bit pending.
    always_comb begin
        pend_a_d = (pend_a_q & ~clr_a) | req_a;
        pend_b_d = (pend_b_q & ~clr_b) | req_b;
        pend_c_d = (pend_c_q & ~clr_c) | req_c;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            pend_a_q  <= '0;
            pend_b_q  <= '0;
            pend_c_q  <= '0;
            gnt_bus_q <= '0;
            gnt_ch_q  <= '0;
        end else begin
            state_q   <= state_d;
            pend_a_q  <= pend_a_d;
            pend_b_q  <= pend_b_d;
            pend_c_q  <= pend_c_d;
            gnt_bus_q <= gnt_bus_d;
            gnt_ch_q  <= gnt_ch_d;
        end
    end

    assign gnt_valid = (state_q == ST_GRANT);
    assign busy      = (state_q == ST_GRANT) || (state_q == ST_SERVICE);
    assign gnt_bus   = gnt_bus_q;
    assign gnt_ch    = gnt_ch_q;
    assign pend_a    = pend_a_q;
    assign pend_b    = pend_b_q;
    assign pend_c    = pend_c_q;
    assign state_dbg = state_q;

endmodule

// File: doc/irq_sched.md
IRQ_SCHED -- requirements
Module: irq_sched

Interface
REQ-001 Parameter NCH, default 9: channels per request bus.
REQ-002 Parameter NBUS, fixed 3: request buses A (highest), B, C (lowest).
REQ-003 The block SHALL use one clock, clk, and a synchronous, active-high reset, rst.
REQ-004 clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 req_a  input  NCH  bus A request levels; bit 0 is the highest-priority channel.
REQ-007 req_b  input  NCH  bus B request levels.
REQ-008 req_c  input  NCH  bus C request levels.
REQ-009 en  input  NCH  per-channel enable, shared by all three buses.
REQ-010 gnt_ack  input  1  requester accepts the presented grant.
REQ-011 eoi  input  1  end-of-interrupt pulse for the channel in service.
REQ-012 gnt_valid  output  1  grant presented.
REQ-013 gnt_bus  output  2  granted bus (0=A, 1=B, 2=C).
REQ-014 gnt_ch  output  4  granted channel index.
REQ-015 busy  output  1  high in GRANT and SERVICE.
REQ-016 pend_a, pend_b, pend_c  output  NCH each  pending registers.

Function
REQ-017 Pending bit [b][i] SHALL set at the edge ending any cycle in which its req bit is 1.
REQ-018 Pending bit [b][i] SHALL clear at the edge where gnt_ack=1 in GRANT and it is the granted bit.
REQ-019 If a set and a clear hit the same bit in the same cycle, set SHALL win and the bit stays 1.
REQ-020 Eligible = pending AND en; a masked pending bit SHALL be retained but never granted.
REQ-021 Priority: any eligible A beats any B, B beats C; within a bus, lowest index wins.
REQ-022 FSM states: IDLE, GRANT, SERVICE.
REQ-023 IDLE -> GRANT when any bit is eligible; the winner is registered into gnt_bus/gnt_ch on that edge.
REQ-024 GRANT -> SERVICE on gnt_ack=1.
REQ-025 SERVICE -> IDLE on eoi=1.
REQ-026 Latency: req asserted in cycle t SHALL give gnt_valid=1 in cycle t+2 if the FSM is IDLE in t+1.
REQ-027 gnt_valid=1 only in GRANT.
REQ-028 gnt_bus/gnt_ch SHALL stay stable from GRANT entry until leaving SERVICE, even if a higher-priority request arrives or en changes.
REQ-029 There is no preemption and no grant retraction.
REQ-030 gnt_ack outside GRANT and eoi outside SERVICE SHALL be ignored.
REQ-031 eoi and gnt_ack together in GRANT: ack is taken, eoi is ignored (one state step per cycle).
REQ-032 In SERVICE, a re-request of the in-service channel SHALL set pending normally and be eligible after IDLE.
REQ-033 Back-to-back: eoi in cycle t with another eligible bit gives gnt_valid in cycle t+2 (IDLE for one cycle).

Reset
REQ-034 rst=1 SHALL force IDLE and clear all pend bits, gnt_valid, gnt_bus, gnt_ch and busy to 0 at the next edge.
REQ-035 rst=1 SHALL take priority over all other inputs, including mid-GRANT or mid-SERVICE; requests in a reset cycle are dropped.

Structure
REQ-036 Package irq_pkg SHALL hold NCH, NBUS, the state enum (IDLE/GRANT/SERVICE) and the bus code constants.
REQ-037 Sub-module irq_prio_resolve SHALL be purely combinational: inputs are 3xNCH eligible bits; outputs are any, bus and ch.
REQ-038 irq_sched SHALL hold all registers.

Verification
REQ-039 Reset then req_c=9'h001, en=9'h1FF for one cycle -> gnt_valid=1 two cycles later, gnt_bus=2, gnt_ch=0, pend_c=9'h001.
REQ-040 req_a=9'h010 and req_b=9'h001 in the same cycle -> first grant bus=0 ch=4; after ack and eoi -> grant bus=1 ch=0.
REQ-041 en=9'h1FE, req_a=9'h001 -> no grant and pend_a bit0 held; then en=9'h1FF -> grant bus=0 ch=0.
REQ-042 In GRANT for bus=2 ch=3, req_a=9'h001 asserted -> gnt_bus/gnt_ch unchanged until eoi; next grant is bus=0 ch=0.
REQ-043 req_b bit2 held high through the ack cycle of grant bus=1 ch=2 -> pend_b bit2 remains 1 and is re-granted after eoi.
REQ-044 rst pulsed during SERVICE with pend_a=9'h0F0 -> next cycle IDLE, all pend=0, busy=0, gnt_valid=0.
